cr_ifu_randclk_ctrl: RTL

- Sequencer for the IFU instruction-buffer random clock-gate module-enables: push, pop and the 4 entry-data groups.
- Replaces constant-zero enables with a seeded 16-bit LFSR pattern that advances every programmable dwell period.
- Pattern is masked by the SEU control word and can be frozen or disabled at any cycle.
- Sits in the IFU between the SEU/CSR config and the ibuf gated-clock cells.

---
 rtl/cr_ifu_randclk_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/cr_ifu_randclk_ctrl.sv
// Random clock-gate enable sequencer for the IFU instruction buffer.
// A seeded 16-bit LFSR, stepped once per dwell period, drives masked push/pop/entry-data enables.
module cr_ifu_randclk_ctrl #(
    parameter int                LFSR_W       = 16,
    parameter int                DWELL_W      = 4,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               randclk_cfg_en,
    input  logic [LFSR_W-1:0]  randclk_cfg_seed,
    input  logic [DWELL_W-1:0] randclk_cfg_dwell,
    input  logic [31:0]        seu_ifu_randclk_mod_en,
    input  logic               ifu_randclk_freeze,
    output logic               randclk_ibuf_push_mod_en_w3,
    output logic               randclk_ibuf_pop_mod_en_w3,
    output logic [3:0]         randclk_ibuf_entry_data_mod_en_w16,
    output logic               randclk_ctrl_busy
);

    typedef enum logic [1:0] {ST_OFF, ST_SEED, ST_RUN, ST_HOLD} state_t;

    state_t             state_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LFSR_W-1:0]  lfsr_d;
    logic [LFSR_W-1:0]  seed_d;
    logic [DWELL_W-1:0] cnt_q;
    logic               push_q;
    logic               pop_q;
    logic [3:0]         entry_q;
    logic               busy_q;
    logic               unused_mask_hi;

    // Taps 16,14,13,11 (maximal length); zero state can never be entered.
    assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign seed_d = (randclk_cfg_seed == '0) ? DEFAULT_SEED : randclk_cfg_seed;
    assign unused_mask_hi = ^seu_ifu_randclk_mod_en[31:6];

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= ST_OFF;
            lfsr_q  <= DEFAULT_SEED;
            cnt_q   <= '0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            entry_q <= '0;
            busy_q  <= 1'b0;
        end else if (!randclk_cfg_en) begin
            // Disable wins over everything, including an active freeze.
            state_q <= ST_OFF;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            entry_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= 1'b1;
            case (state_q)
                ST_OFF: begin
                    state_q <= ST_SEED;
                    push_q  <= 1'b0;
                    pop_q   <= 1'b0;
                    entry_q <= '0;
                end
                ST_SEED: begin
                    state_q <= ST_RUN;
                    lfsr_q  <= seed_d;
                    cnt_q   <= '0;
                end
                ST_RUN: begin
                    if (ifu_randclk_freeze) begin
                        state_q <= ST_HOLD;
                    end else if (cnt_q == randclk_cfg_dwell) begin
                        cnt_q   <= '0;
                        lfsr_q  <= lfsr_d;
                        push_q  <= lfsr_d[0] & seu_ifu_randclk_mod_en[0];
                        pop_q   <= lfsr_d[1] & seu_ifu_randclk_mod_en[1];
                        entry_q <= lfsr_d[5:2] & seu_ifu_randclk_mod_en[5:2];
                    end else begin
                        cnt_q <= cnt_q + DWELL_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!ifu_randclk_freeze) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_OFF;
            endcase
        end
    end

    assign randclk_ibuf_push_mod_en_w3        = push_q;
    assign randclk_ibuf_pop_mod_en_w3         = pop_q;
    assign randclk_ibuf_entry_data_mod_en_w16 = entry_q;
    assign randclk_ctrl_busy                  = busy_q;

endmodule
